imm_splitter: RTL and testbench

IMM_SPLITTER -- requirements
Module: imm_splitter

---
 rtl/imm_splitter.sv | 104 ++++++++++
 tb/tb_imm_splitter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/imm_splitter.sv
// rtl/imm_splitter.sv - splits a 32-bit constant into minimal sign-extended 6-bit immediate chunks
module imm_splitter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_imm,
    output logic        out_first,
    output logic        out_last,
    output logic [2:0]  out_count
);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t      r_state;
    logic [31:0] r_value;
    logic [2:0]  r_k;
    logic [2:0]  r_n;

    logic [2:0]  w_n;
    logic [2:0]  w_k_next;

    // Smallest n whose top chunk, sign-extended, reproduces the whole value.
    function automatic logic [2:0] f_chunks(input logic [31:0] v);
        logic [31:0] t;
        logic [2:0]  n;
        n = 3'd6;
        for (int i = 5; i >= 1; i--) begin
            t = $signed(v) >>> (6 * i - 1);
            if (t == '0 || t == '1) begin
                n = 3'(i);
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] f_chunk(input logic [31:0] v, input logic [2:0] n,
                                           input logic [2:0] k);
        logic [35:0] s;
        logic [2:0]  idx;
        idx = n - k - 3'd1;
        s   = {{4{v[31]}}, v} >> (6 * idx);
        return s[5:0];
    endfunction

    assign w_n      = f_chunks(in_value);
    assign w_k_next = r_k + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_value   <= '0;
            r_k       <= '0;
            r_n       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state   <= S_EMIT;
                        r_value   <= in_value;
                        r_n       <= w_n;
                        r_k       <= '0;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_imm   <= f_chunk(in_value, w_n, 3'd0);
                        out_first <= 1'b1;
                        out_last  <= (w_n == 3'd1);
                        out_count <= w_n;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            r_state   <= S_IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_first <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            r_k       <= w_k_next;
                            out_imm   <= f_chunk(r_value, r_n, w_k_next);
                            out_first <= 1'b0;
                            out_last  <= (w_k_next == r_n - 3'd1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_splitter.sv
// tb/tb_imm_splitter.sv - scoreboard bench for imm_splitter
module tb_imm_splitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_imm;
    logic        out_first;
    logic        out_last;
    logic [2:0]  out_count;

    int n_vec = 0;
    int n_err = 0;

    logic [10:0] sb[$];
    logic [31:0] vq[$];
    logic [31:0] acc;

    always #5 clk = ~clk;

    imm_splitter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_first (out_first),
        .out_last  (out_last),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_n(input logic [31:0] v);
        int sh;
        for (int n = 1; n <= 5; n++) begin
            sh = 32 - 6 * n;
            if (((int'(v) <<< sh) >>> sh) == int'(v)) return n;
        end
        return 6;
    endfunction

    task automatic exp_chunk(input logic [5:0] imm, input bit f, input bit l, input logic [2:0] c);
        sb.push_back({imm, f, l, c});
    endtask

    task automatic push_model(input logic [31:0] v);
        logic [35:0] s;
        int n;
        n = model_n(v);
        s = {{4{v[31]}}, v};
        for (int k = 0; k < n; k++) begin
            logic [35:0] t;
            t = s >> (6 * (n - 1 - k));
            exp_chunk(t[5:0], k == 0, k == n - 1, 3'(n));
        end
    endtask

    // Every valid chunk is checked against the scoreboard head; popped only on transfer.
    always @(negedge clk) begin
        if (rst) begin
            acc = '0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_chunk", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("chunk", {21'd0, out_imm, out_first, out_last, out_count}, {21'd0, sb[0]});
                if (out_ready) begin
                    void'(sb.pop_front());
                    if (out_first) acc = {{26{out_imm[5]}}, out_imm};
                    else           acc = {acc[25:0], out_imm};
                    if (out_last && vq.size() > 0) chk("recon", acc, vq.pop_front());
                end
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge where in_ready is back.
    task automatic run_value(input logic [31:0] v, input int mode, input int stall, input bit use_model);
        int  n;
        int  cyc;
        bit  done;
        if (use_model) push_model(v);
        vq.push_back(v);
        n        = sb.size();
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 200) begin
            cyc++;
            in_valid = 1'($urandom_range(0, 1));
            in_value = $urandom;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc > stall);
            endcase
            @(negedge clk);
            if (cyc == 1) chk("first_latency", {31'd0, out_valid}, 32'd1);
            if (in_ready) begin
                done     = 1'b1;
                in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) chk("timeout", {31'd0, in_ready}, 32'd1);
        else if (mode != 1) chk("occupancy", cyc, n + 1 + stall);
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {21'd0, in_ready, out_valid, out_imm, out_first, out_last, out_count},
            {21'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 3'd0});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);

        exp_chunk(6'h05, 1, 1, 3'd1);
        run_value(32'h0000_0005, 0, 0, 0);
        exp_chunk(6'h20, 1, 1, 3'd1);
        run_value(32'hFFFF_FFE0, 0, 0, 0);
        exp_chunk(6'h00, 1, 0, 3'd2);
        exp_chunk(6'h20, 0, 1, 3'd2);
        run_value(32'h0000_0020, 0, 0, 0);
        exp_chunk(6'h3E, 1, 0, 3'd6);
        for (int i = 0; i < 4; i++) exp_chunk(6'h00, 0, 0, 3'd6);
        exp_chunk(6'h00, 0, 1, 3'd6);
        run_value(32'h8000_0000, 0, 0, 0);
        exp_chunk(6'h12, 1, 0, 3'd5);
        exp_chunk(6'h0D, 0, 0, 3'd5);
        exp_chunk(6'h05, 0, 0, 3'd5);
        exp_chunk(6'h19, 0, 0, 3'd5);
        exp_chunk(6'h38, 0, 1, 3'd5);
        run_value(32'h1234_5678, 2, 3, 0);

        // Reset while the third chunk of 0x80000000 is on the bus.
        push_model(32'h8000_0000);
        vq.push_back(32'h8000_0000);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_value  = 32'h8000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        vq.delete();
        @(negedge clk);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        exp_chunk(6'h01, 1, 1, 3'd1);
        run_value(32'h0000_0001, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] v;
            v = int'($urandom) >>> $urandom_range(0, 31);
            run_value(v, (i % 4 == 0) ? 0 : 1, 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
